// File: rtl/ps2_pkg.sv
// Shared state encoding, widths and parameter defaults for the PS/2 receive path.
package ps2_pkg;

    localparam int unsigned PS2_DATA_BITS          = 8;
    localparam int unsigned PS2_FILTER_DEFAULT     = 8;
    localparam int unsigned PS2_TIMEOUT_DEFAULT    = 1600;
    localparam int unsigned PS2_FIFO_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // True when data plus parity hold an odd number of ones.
    function automatic logic odd_ones(input logic [PS2_DATA_BITS:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side receive bus: FIFO head, pop handshake and status flags.
interface ps2_rx_fifo_if;
    import ps2_pkg::*;

    logic [PS2_DATA_BITS-1:0] RX_DATA;
    logic                     RX_VALID;
    logic                     RX_READ;
    logic                     RX_ERROR;
    logic                     RX_OVERFLOW;
    logic                     BUSY;

    modport master (
        output RX_DATA, RX_VALID, RX_ERROR, RX_OVERFLOW, BUSY,
        input  RX_READ
    );

    modport slave (
        input  RX_DATA, RX_VALID, RX_ERROR, RX_OVERFLOW, BUSY,
        output RX_READ
    );

endinterface

// File: rtl/ps2_fifo.sv
// First-word-fall-through FIFO with registered head/flags; pop is applied before push.
module ps2_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             CLK_en,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]    count_q, count_n;
    logic [WIDTH-1:0] head_n;
    logic             do_push_c, do_pop_c;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop_c  = CLK_en && pop && !empty;
        do_push_c = CLK_en && push && (!full || do_pop_c);
        wr_ptr_n  = wr_ptr_q + AW'(do_push_c);
        rd_ptr_n  = rd_ptr_q + AW'(do_pop_c);
        count_n   = count_q + CW'(do_push_c) - CW'(do_pop_c);
        head_n    = (do_push_c && (wr_ptr_q == rd_ptr_n)) ? din : mem_q[rd_ptr_n];
    end

    always_ff @(posedge CLK) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout     <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else if (CLK_en) begin
            wr_ptr_q <= wr_ptr_n;
            rd_ptr_q <= rd_ptr_n;
            count_q  <= count_n;
            dout     <= head_n;
            empty    <= (count_n == CW'(0));
            full     <= (count_n == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a FWFT byte FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = PS2_FIFO_DEPTH_DEFAULT,
    parameter int unsigned FILTER     = PS2_FILTER_DEFAULT,
    parameter int unsigned TIMEOUT    = PS2_TIMEOUT_DEFAULT
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          CLK_en,
    input  logic          PS2_CLK,
    input  logic          PS2_DATA,
    ps2_rx_fifo_if.master rx
);

    localparam int unsigned FW = $clog2(FILTER + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW = $clog2(PS2_DATA_BITS);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHECK_EN = 1'b1;
`else
    localparam bit PAR_CHECK_EN = 1'b0;
`endif

    logic [1:0]               clk_sync_q, dat_sync_q;
    logic                     clk_s, data_s;
    logic [FW-1:0]            flt_cnt_q;
    logic                     flt_clk_q;
    logic                     sample_c;

    ps2_state_e               state_q, state_n;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_n;
    logic [PS2_DATA_BITS-1:0] shreg_q, shreg_n;
    logic                     par_q, par_n;
    logic [TW-1:0]            tmo_q, tmo_n;
    logic                     err_q, err_n;
    logic                     busy_q, ovf_q;
    logic                     push_c, pop_c, par_ok_c;
    logic                     fifo_empty, fifo_full;

    // Pin synchronisers run every CLK edge, independent of CLK_en.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DATA};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = dat_sync_q[1];

    // Filtered clock follows the pin only after FILTER consecutive agreeing samples.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            flt_clk_q <= 1'b1;
            flt_cnt_q <= '0;
        end else if (CLK_en) begin
            if (clk_s == flt_clk_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FW'(FILTER - 1)) begin
                flt_clk_q <= clk_s;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
        end
    end

    assign sample_c = CLK_en && flt_clk_q && !clk_s && (flt_cnt_q == FW'(FILTER - 1));
    assign par_ok_c = !PAR_CHECK_EN || odd_ones({shreg_q, par_q});
    assign pop_c    = rx.RX_READ && !fifo_empty;

    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        shreg_n   = shreg_q;
        par_n     = par_q;
        tmo_n     = '0;
        err_n     = 1'b0;
        push_c    = 1'b0;

        if ((state_q != IDLE) && !sample_c) begin
            tmo_n = tmo_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (sample_c && !data_s) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    shreg_n   = '0;
                end
            end
            DATA: begin
                if (sample_c) begin
                    shreg_n   = {data_s, shreg_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (sample_c) begin
                    par_n   = data_s;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (sample_c) begin
                    if (data_s && par_ok_c) begin
                        push_c = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
        endcase

        // A stalled frame is abandoned; a sample point in the same cycle takes priority.
        if ((state_q != IDLE) && !sample_c && (tmo_q == TW'(TIMEOUT - 1))) begin
            state_n = IDLE;
            err_n   = 1'b1;
            tmo_n   = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (CLK_en) begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            shreg_q   <= shreg_n;
            par_q     <= par_n;
            tmo_q     <= tmo_n;
            err_q     <= err_n;
            busy_q    <= (state_n != IDLE);
            if (push_c && fifo_full && !pop_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_DATA_BITS)
    ) u_fifo (
        .CLK    (CLK),
        .nRESET (nRESET),
        .CLK_en (CLK_en),
        .push   (push_c),
        .din    (shreg_q),
        .pop    (rx.RX_READ),
        .dout   (rx.RX_DATA),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign rx.RX_VALID    = !fifo_empty;
    assign rx.RX_ERROR    = err_q;
    assign rx.RX_OVERFLOW = ovf_q;
    assign rx.BUSY        = busy_q;

endmodule
